ahb3lite_cmd_master: RTL and testbench

Single-outstanding AHB3-Lite bus master. It turns a valid/ready command stream (address, data, direction, size) into one AHB3-Lite SINGLE transfer and returns read data and error status on a valid/ready response stream. It sits directly upstream of AHB3-Lite slaves such as the CSR slave, through the interconnect. Typical requesters are debug bridges and UART/SPI command decoders.

---
 rtl/ahb3lite_cmd_master.sv | 97 +++++++++
 tb/tb_ahb3lite_cmd_master.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_cmd_master.sv
// ahb3lite_cmd_master: single-outstanding AHB3-Lite master turning a cmd/rsp stream into SINGLE transfers.
// Define AHB3LITE_CMD_ALIGN_CHECK_EN to reject oversized or misaligned commands locally without bus activity.
module ahb3lite_cmd_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WRITE,
  input  logic [31:0] CMD_ADDR,
  input  logic [31:0] CMD_WDATA,
  input  logic [2:0]  CMD_SIZE,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [1:0]  HTRANS,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADDR = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] ERR2 = 3'd3;
  localparam logic [2:0] RESP = 3'd4;
  logic [2:0]  state;
  logic [31:0] wdata_q;
  logic        rej;
`ifdef AHB3LITE_CMD_ALIGN_CHECK_EN
  assign rej = (CMD_SIZE > 3'd2) || (CMD_SIZE == 3'd1 && CMD_ADDR[0]) ||
               (CMD_SIZE == 3'd2 && CMD_ADDR[1:0] != 2'b00);
`else
  assign rej = 1'b0;
`endif
  assign CMD_READY = state == IDLE;
  assign RSP_VALID = state == RESP;
  assign HTRANS    = state == ADDR ? 2'b10 : 2'b00;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= IDLE;
      wdata_q   <= '0;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HSIZE     <= '0;
      HWDATA    <= '0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (CMD_VALID) begin
          wdata_q <= CMD_WDATA;
          if (rej) begin
            RSP_ERR   <= 1'b1;
            RSP_RDATA <= '0;
            state     <= RESP;
          end else begin
            HADDR  <= CMD_ADDR;
            HWRITE <= CMD_WRITE;
            HSIZE  <= CMD_SIZE;
            state  <= ADDR;
          end
        end
        ADDR: if (HREADY) begin
          HWDATA <= wdata_q;
          state  <= DATA;
        end
        // an OKAY completion returns data; HREADY high with HRESP high is treated as an error
        DATA: if (HREADY) begin
          RSP_ERR   <= HRESP;
          RSP_RDATA <= (HWRITE || HRESP) ? 32'd0 : HRDATA;
          state     <= RESP;
        end else if (HRESP) begin
          state <= ERR2;
        end
        ERR2: if (HREADY) begin
          RSP_ERR   <= 1'b1;
          RSP_RDATA <= '0;
          state     <= RESP;
        end
        RESP: if (RSP_READY) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb3lite_cmd_master.sv
// tb_ahb3lite_cmd_master: directed and random commands checked against a per-command latency/response model.
module tb_ahb3lite_cmd_master;
  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        CMD_VALID, CMD_READY, CMD_WRITE;
  logic [31:0] CMD_ADDR, CMD_WDATA;
  logic [2:0]  CMD_SIZE;
  logic        RSP_VALID, RSP_READY, RSP_ERR;
  logic [31:0] RSP_RDATA;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  int checks = 0;
  int failures = 0;

  ahb3lite_cmd_master dut (
    .CLK(CLK), .RESETn(RESETn),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_SIZE(CMD_SIZE),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk1(input string tag, input logic o, input logic e);
    chk(tag, {31'd0, o}, {31'd0, e});
  endtask

  function automatic bit reject(input logic [31:0] a, input logic [2:0] s);
`ifdef AHB3LITE_CMD_ALIGN_CHECK_EN
    return (s > 3'd2) || ((a % (32'd1 << s)) != 0);
`else
    return (a == 32'd0) && (s == 3'd7) && 1'b0;
`endif
  endfunction

  task automatic reset_chk();
    chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk1("rst_hwrite", HWRITE, 1'b0);
    chk("rst_hsize", {29'd0, HSIZE}, 32'd0);
    chk("rst_hburst", {29'd0, HBURST}, 32'd0);
    chk1("rst_hmastlock", HMASTLOCK, 1'b0);
    chk("rst_hprot", {28'd0, HPROT}, 32'h3);
    chk1("rst_rsp_valid", RSP_VALID, 1'b0);
    chk1("rst_rsp_err", RSP_ERR, 1'b0);
    chk("rst_rsp_rdata", RSP_RDATA, 32'd0);
  endtask

  // Entered and left at #1 after a rising edge with the DUT expected idle.
  // aw = address-phase wait cycles, dw = data-phase wait cycles, e = two-cycle ERROR, bp = RSP_READY low cycles.
  task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] sz,
                         input int aw, input int dw, input bit e, input logic [31:0] rd, input int bp);
    bit rej, exp_err, seen;
    int lat, c;
    logic [31:0] exp_rd;
    rej = reject(a, sz);
    lat = rej ? 1 : 3 + aw + dw + (e ? 1 : 0);
    exp_err = rej || e;
    exp_rd = (exp_err || w) ? 32'd0 : rd;
    @(negedge CLK);
    chk1("cmd_ready_idle", CMD_READY, 1'b1);
    CMD_VALID = 1'b1; CMD_WRITE = w; CMD_ADDR = a; CMD_WDATA = wd; CMD_SIZE = sz;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0; CMD_WRITE = ~w; CMD_ADDR = $urandom; CMD_WDATA = $urandom; CMD_SIZE = 3'($urandom);
    seen = 1'b0;
    c = 0;
    while (!seen && c < lat + 3) begin
      c++;
      HRESP = 1'b0; HREADY = 1'b1; HRDATA = $urandom;
      if (!rej) begin
        if (c <= aw) HREADY = 1'b0;
        else if (c > aw + 1 && c <= aw + 1 + dw) HREADY = 1'b0;
        else if (c == aw + 2 + dw) begin
          if (e) begin HREADY = 1'b0; HRESP = 1'b1; end
          else HRDATA = rd;
        end else if (e && c == aw + 3 + dw) HRESP = 1'b1;
      end
      @(negedge CLK);
      if (RSP_VALID) seen = 1'b1;
      else begin
        chk1("busy_cmd_ready", CMD_READY, 1'b0);
        chk("htrans", {30'd0, HTRANS}, (!rej && c <= aw + 1) ? 32'd2 : 32'd0);
        if (!rej && c <= aw + 1) begin
          chk("haddr", HADDR, a);
          chk1("hwrite", HWRITE, w);
          chk("hsize", {29'd0, HSIZE}, {29'd0, sz});
        end
        if (!rej && c > aw + 1) chk("hwdata", HWDATA, wd);
        @(posedge CLK); #1;
      end
    end
    chk("rsp_latency", c, lat);
    HREADY = 1'b1; HRESP = 1'b0;
    for (int k = 0; k <= bp; k++) begin
      if (k > 0) begin
        CMD_VALID = 1'b1; CMD_ADDR = $urandom; CMD_WDATA = $urandom;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk1("bp_cmd_ready", CMD_READY, 1'b0);
      end
      chk1("rsp_valid", RSP_VALID, 1'b1);
      chk1("rsp_err", RSP_ERR, exp_err);
      chk("rsp_rdata", RSP_RDATA, exp_rd);
      chk("rsp_htrans", {30'd0, HTRANS}, 32'd0);
    end
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0; CMD_VALID = 1'b0;
  endtask

  initial begin
    logic w;
    logic [2:0] sz;
    logic [31:0] a;
    CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0; CMD_SIZE = '0;
    RSP_READY = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    #2;
    reset_chk();
    @(negedge CLK);
    RESETn = 1'b1;
    @(posedge CLK); #1;
    run_cmd(1'b1, 32'h0000_0004, 32'hA5A5_1234, 3'd2, 0, 0, 1'b0, 32'h0, 0);
    run_cmd(1'b0, 32'h0000_0008, 32'h1111_2222, 3'd2, 0, 3, 1'b0, 32'hDEAD_BEEF, 0);
    run_cmd(1'b0, 32'h0000_000C, 32'h0, 3'd2, 0, 0, 1'b1, 32'hCAFE_F00D, 0);
    run_cmd(1'b1, 32'h0000_0100, 32'h0000_BEEF, 3'd1, 1, 1, 1'b0, 32'h0, 5);
    run_cmd(1'b0, 32'h0000_0002, 32'h0, 3'd2, 0, 0, 1'b0, 32'h1234_5678, 0);
    run_cmd(1'b0, 32'h0000_0003, 32'h0, 3'd0, 2, 0, 1'b0, 32'h8765_4321, 1);
    // reset while the transfer sits in its data phase
    @(negedge CLK);
    chk1("pre_rst_cmd_ready", CMD_READY, 1'b1);
    CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h40; CMD_WDATA = 32'h1357_9BDF; CMD_SIZE = 3'd2;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    @(posedge CLK); #1;
    HREADY = 1'b0;
    @(negedge CLK);
    chk("pre_rst_hwdata", HWDATA, 32'h1357_9BDF);
    #1 RESETn = 1'b0;
    #1 reset_chk();
    @(negedge CLK);
    RESETn = 1'b1; HREADY = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      chk1("post_rst_rsp_valid", RSP_VALID, 1'b0);
      chk1("post_rst_cmd_ready", CMD_READY, 1'b1);
      chk("post_rst_htrans", {30'd0, HTRANS}, 32'd0);
    end
    @(posedge CLK); #1;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 3) != 0 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
      run_cmd(w, a, $urandom, sz, $urandom_range(0, 2), $urandom_range(0, 3),
              $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 2));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
